// File: rtl/trng_postproc.sv
// trng_postproc: raw-bit synchroniser, Von Neumann corrector, MSB-first word packer
// and output register. Define TRNG_HEALTH_EN to add the repetition-count health test.
module trng_postproc #(
   parameter int OUT_W      = 8,
   parameter int RCT_CUTOFF = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             raw_bit,
   input  logic             raw_valid,
   input  logic             vn_en,
   output logic [OUT_W-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic [7:0]       drop_cnt,
   output logic             health_fail,
   input  logic             clr_fail
);

   localparam int CW = $clog2(OUT_W);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HAVE1 = 1'b1;

   // raw_valid takes the same two flops as raw_bit so (sb, sv) stay aligned
   logic sync1;
   logic sb;
   logic vld1;
   logic sv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sb    <= 1'b0;
         vld1  <= 1'b0;
         sv    <= 1'b0;
      end else begin
         sync1 <= raw_bit;
         sb    <= sync1;
         vld1  <= raw_valid;
         sv    <= vld1;
      end
   end

   logic [0:0] vn_state;
   logic [0:0] vn_state_n;
   logic       first_bit;
   logic       first_bit_n;
   logic       emit;
   logic       emit_bit;

   // Corrector off or block disabled: pair state collapses to EMPTY, dropping any stored bit
   always_comb begin
      vn_state_n  = vn_state;
      first_bit_n = first_bit;
      emit        = 1'b0;
      emit_bit    = sb;
      if (!en || !vn_en) begin
         vn_state_n = ST_EMPTY;
         emit       = en & sv;
      end else if (sv) begin
         case (vn_state)
            ST_EMPTY: begin
               first_bit_n = sb;
               vn_state_n  = ST_HAVE1;
            end
            default: begin
               vn_state_n = ST_EMPTY;
               emit       = first_bit ^ sb;
               emit_bit   = first_bit;
            end
         endcase
      end
   end

   logic emit_v;
   logic emit_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vn_state  <= ST_EMPTY;
         first_bit <= 1'b0;
         emit_v    <= 1'b0;
         emit_b    <= 1'b0;
      end else begin
         vn_state  <= vn_state_n;
         first_bit <= first_bit_n;
         emit_v    <= emit;
         emit_b    <= emit_bit;
      end
   end

   logic [OUT_W-2:0] sh;
   logic [CW-1:0]    cnt;
   logic [OUT_W-1:0] word;
   logic             word_done;

   assign word      = {sh, emit_b};
   assign word_done = en && emit_v && (cnt == CW'(OUT_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh  <= '0;
         cnt <= '0;
      end else if (!en) begin
         sh  <= '0;
         cnt <= '0;
      end else if (emit_v) begin
         sh  <= word[OUT_W-2:0];
         cnt <= word_done ? '0 : cnt + CW'(1);
      end
   end

   // Handshake: a word transfers on any clk edge where data_valid && data_ready;
   // data_out is held while data_valid && !data_ready, and a new word may load
   // in the same cycle the current one is consumed.
   logic load_ok;
   logic load_req;

   assign load_ok  = !data_valid || data_ready;
   assign load_req = word_done && !health_fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         drop_cnt   <= 8'd0;
      end else if (load_req && load_ok) begin
         data_out   <= word;
         data_valid <= 1'b1;
      end else if (load_req) begin
         if (drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end else if (data_valid && data_ready) begin
         data_valid <= 1'b0;
      end
   end

`ifdef TRNG_HEALTH_EN
   logic [5:0] run;
   logic [5:0] run_n;
   logic       prev_bit;
   logic       trip;

   // Run length of identical raw bits, counted before correction and saturating at 63
   always_comb begin
      if (run != 6'd0 && sb == prev_bit)
         run_n = (run == 6'd63) ? run : run + 6'd1;
      else
         run_n = 6'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 6'd0;
         prev_bit    <= 1'b0;
         trip        <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         if (sv) begin
            run      <= run_n;
            prev_bit <= sb;
         end
         trip <= sv && (run_n >= 6'(RCT_CUTOFF));
         // a trip arriving with clr_fail keeps the flag set
         if (trip)
            health_fail <= 1'b1;
         else if (clr_fail)
            health_fail <= 1'b0;
      end
   end
`else
   logic unused_clr_fail;
   assign unused_clr_fail = clr_fail;
   assign health_fail     = 1'b0;
`endif

endmodule

// File: tb/tb_trng_postproc.sv
// Bench for trng_postproc: directed bit streams, a word-level model with a per-cycle
// output compare, and literal expectations for the documented scenarios.
module tb_trng_postproc;

   localparam int OUT_W = 8;
   localparam int CUT   = 31;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic             en         = 1'b0;
   logic             raw_bit    = 1'b0;
   logic             raw_valid  = 1'b0;
   logic             vn_en      = 1'b0;
   logic             data_ready = 1'b0;
   logic             clr_fail   = 1'b0;
   logic [OUT_W-1:0] data_out;
   logic             data_valid;
   logic [7:0]       drop_cnt;
   logic             health_fail;

   trng_postproc #(.OUT_W(OUT_W), .RCT_CUTOFF(CUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .raw_bit     (raw_bit),
      .raw_valid   (raw_valid),
      .vn_en       (vn_en),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .drop_cnt    (drop_cnt),
      .health_fail (health_fail),
      .clr_fail    (clr_fail)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: words completed by the bit stream, scheduled to reach the output register
   typedef struct {
      int               e;
      logic [OUT_W-1:0] w;
   } arr_t;

   arr_t             arr_q[$];
   int               hf_q[$];
   logic             pair_q[$];
   logic             bits_q[$];
   logic [OUT_W-1:0] exp_q[$];
   logic [OUT_W-1:0] acc_q[$];
   logic             exp_valid = 1'b0;
   logic [OUT_W-1:0] exp_data  = '0;
   logic [7:0]       exp_drop  = 8'd0;
   logic             exp_hf    = 1'b0;
   int               run       = 0;
   logic             prev_b    = 1'b0;

   task automatic model_flush();
      pair_q.delete();
      bits_q.delete();
   endtask

   task automatic model_reset();
      model_flush();
      arr_q.delete();
      hf_q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_drop  = 8'd0;
      exp_hf    = 1'b0;
      run       = 0;
      prev_b    = 1'b0;
   endtask

   task automatic model_emit(input logic b, input int e);
      logic [OUT_W-1:0] w;
      arr_t a;
      bits_q.push_back(b);
      if (bits_q.size() == OUT_W) begin
         w = '0;
         foreach (bits_q[i]) w = {w[OUT_W-2:0], bits_q[i]};
         a.e = e + 3;
         a.w = w;
         arr_q.push_back(a);
         bits_q.delete();
      end
   endtask

   // e is the clock edge at which the DUT samples this raw bit
   task automatic model_push(input logic b, input int e);
`ifdef TRNG_HEALTH_EN
      if (run != 0 && b == prev_b) begin
         if (run < 63) run++;
      end else begin
         run = 1;
      end
      prev_b = b;
      if (run >= CUT) hf_q.push_back(e + 3);
`endif
      if (!en) return;
      if (vn_en) begin
         pair_q.push_back(b);
         if (pair_q.size() == 2) begin
            if (pair_q[0] != pair_q[1]) model_emit(pair_q[0], e);
            pair_q.delete();
         end
      end else begin
         model_emit(b, e);
      end
   endtask

   always @(posedge clk) begin
      logic hs;
      logic arrive;
      logic set_hf;
      logic [OUT_W-1:0] w;
      cyc = cyc + 1;
      if (rst_n) begin
         hs     = exp_valid && data_ready;
         arrive = 1'b0;
         set_hf = 1'b0;
         w      = '0;
         if (hs) exp_q.push_back(exp_data);
         if (arr_q.size() > 0 && arr_q[0].e == cyc) begin
            arrive = 1'b1;
            w      = arr_q[0].w;
            void'(arr_q.pop_front());
         end
         if (arrive && !exp_hf) begin
            if (!exp_valid || hs) begin
               exp_valid = 1'b1;
               exp_data  = w;
            end else if (exp_drop != 8'hFF) begin
               exp_drop = exp_drop + 8'd1;
            end
         end else if (hs) begin
            exp_valid = 1'b0;
         end
         while (hf_q.size() > 0 && hf_q[0] <= cyc) begin
            if (hf_q[0] == cyc) set_hf = 1'b1;
            void'(hf_q.pop_front());
         end
         if (set_hf) exp_hf = 1'b1;
         else if (clr_fail) exp_hf = 1'b0;
      end
   end

   // Per-cycle compare plus capture of every word the DUT hands over
   logic             seen_valid = 1'b0;
   logic [OUT_W-1:0] seen_data  = '0;

   always @(posedge clk) begin
      #1;
      if (seen_valid && data_ready) acc_q.push_back(seen_data);
      seen_valid = rst_n ? data_valid : 1'b0;
      seen_data  = data_out;
      check("cyc_data_valid", data_valid, exp_valid);
      check("cyc_data_out", data_out, exp_data);
      check("cyc_drop_cnt", drop_cnt, exp_drop);
      check("cyc_health_fail", health_fail, exp_hf);
   end

   task automatic send_bit(input logic b, output int e);
      @(negedge clk);
      raw_bit   = b;
      raw_valid = 1'b1;
      e         = cyc + 1;
      model_push(b, e);
   endtask

   task automatic send_bits(input logic [63:0] v, input int n, output int e);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], e);
      @(negedge clk);
      raw_valid = 1'b0;
      raw_bit   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int e;
      idle(2);
      #1;
      check("reset_data_valid", data_valid, 1'b0);
      check("reset_data_out", data_out, 8'h00);
      check("reset_drop_cnt", drop_cnt, 8'h00);
      check("reset_health_fail", health_fail, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      idle(2);

      // pass-through word and exact latency
      do_reset();
      data_ready = 1'b0;
      send_bits(64'b10110010, 8, e);
      wait_edge(e + 2);
      check("t1_not_early", data_valid, 1'b0);
      wait_edge(e + 3);
      check("t1_valid", data_valid, 1'b1);
      check("t1_data", data_out, 8'hB2);
      check("t1_model", exp_data, 8'hB2);
      @(negedge clk);
      data_ready = 1'b1;
      idle(3);

      // Von Neumann pairs
      do_reset();
      data_ready = 1'b0;
      vn_en      = 1'b1;
      send_bits(64'b01_10_00_11_10_01_01_10_10_01_11, 22, e);
      wait_edge(e + 3);
      check("t2_valid", data_valid, 1'b1);
      check("t2_data", data_out, 8'h66);
      check("t2_model", exp_data, 8'h66);
      @(negedge clk);
      vn_en = 1'b0;
      model_flush();
      idle(2);

      // backpressure: first word held, second dropped
      do_reset();
      data_ready = 1'b0;
      send_bits(64'h3CC3, 16, e);
      wait_edge(e + 5);
      check("t3_valid", data_valid, 1'b1);
      check("t3_held", data_out, 8'h3C);
      check("t3_drop", drop_cnt, 8'd1);
      check("t3_model_drop", exp_drop, 8'd1);
      acc_q.delete();
      @(negedge clk);
      data_ready = 1'b1;
      @(posedge clk);
      #2;
      check("t3_valid_fall", data_valid, 1'b0);
      check("t3_accepted", (acc_q.size() == 1) ? acc_q[0] : 8'hXX, 8'h3C);
      idle(2);

      // reset mid-word
      do_reset();
      data_ready = 1'b0;
      send_bits(64'h5A, 8, e);
      send_bits(64'b11010, 5, e);
      wait_edge(e + 3);
      check("t5_before", data_out, 8'h5A);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("t5_rst_valid", data_valid, 1'b0);
      check("t5_rst_data", data_out, 8'h00);
      check("t5_rst_drop", drop_cnt, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      send_bits(64'hA5, 8, e);
      wait_edge(e + 3);
      check("t5_valid", data_valid, 1'b1);
      check("t5_data", data_out, 8'hA5);

      // en=0 flushes the partial word and ignores bits
      do_reset();
      data_ready = 1'b0;
      send_bits(64'b10110, 5, e);
      idle(4);
      en = 1'b0;
      model_flush();
      send_bits(64'b111111, 6, e);
      idle(4);
      en = 1'b1;
      send_bits(64'h81, 8, e);
      wait_edge(e + 3);
      check("t7_valid", data_valid, 1'b1);
      check("t7_data", data_out, 8'h81);
      check("t7_model", exp_data, 8'h81);

`ifdef TRNG_HEALTH_EN
      // repetition-count trip, blocked loads, clear
      do_reset();
      data_ready = 1'b1;
      send_bits(64'h7FFF_FFFF, 31, e);
      wait_edge(e + 4);
      check("t4_fail_set", health_fail, 1'b1);
      check("t4_model_fail", exp_hf, 1'b1);
      send_bits(64'h0_5555, 17, e);
      wait_edge(e + 5);
      check("t4_no_load", data_valid, 1'b0);
      check("t4_no_drop", drop_cnt, 8'd0);
      check("t4_still_fail", health_fail, 1'b1);
      @(negedge clk);
      clr_fail = 1'b1;
      @(negedge clk);
      clr_fail = 1'b0;
      #1;
      check("t4_cleared", health_fail, 1'b0);
      data_ready = 1'b0;
      send_bits(64'h96, 8, e);
      wait_edge(e + 3);
      check("t4_reload", data_out, 8'h96);
      check("t4_reload_valid", data_valid, 1'b1);
`else
      // long run of ones without the health test
      do_reset();
      data_ready = 1'b1;
      acc_q.delete();
      exp_q.delete();
      send_bits('1, 64, e);
      wait_edge(e + 6);
      check("t6_fail_low", health_fail, 1'b0);
      check("t6_words", acc_q.size(), 8);
      check("t6_model_words", exp_q.size(), 8);
      foreach (acc_q[i]) check("t6_word_ff", acc_q[i], 8'hFF);
`endif

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
